ub_arbiter: RTL and testbench

Shares the unified buffer port between NUM_REQ requesters: RX-FIFO writer, TX-FIFO reader, compute loader/writeback, and controller store path. Grants are round-robin, one transaction at a time. The block muxes the granted requester's control and address onto the buffer and routes buffer_done back as a per-requester done pulse. It also enforces a hold timeout so a stalled transaction cannot lock the buffer.

---
 rtl/ub_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ub_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ub_arbiter.sv
// Round-robin arbiter for the unified buffer port: latches the winning
// requester's command, drives the buffer from the latch, and returns done/timeout.
module ub_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDRESS_SIZE = 9,
    parameter int MAX_HOLD     = 64,
    parameter int CNT_WIDTH    = $clog2(MAX_HOLD + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ-1:0]              req_re,
    input  logic [2*NUM_REQ-1:0]            req_mode,
    input  logic [NUM_REQ-1:0]              req_section,
    input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_addr,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              done,
    output logic                            timeout_err,
    output logic                            busy,
    output logic                            ub_we,
    output logic                            ub_re,
    output logic                            ub_fifo_en,
    output logic                            ub_compute_en,
    output logic                            ub_store_en,
    output logic                            ub_section,
    output logic [ADDRESS_SIZE-1:0]         ub_address,
    input  logic                            ub_done
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_RELEASE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        r_owner;
    logic                    r_we;
    logic                    r_re;
    logic [1:0]              r_mode;
    logic                    r_section;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    r_done_pulse;
    logic                    r_err_pulse;

    logic [NUM_REQ-1:0]      w_rot;
    logic                    w_found;
    logic [PTR_W-1:0]        w_off;
    logic [SUM_W-1:0]        w_win_sum;
    logic [PTR_W-1:0]        w_win;
    logic [1:0]              w_mode_arr [NUM_REQ];
    logic [ADDRESS_SIZE-1:0] w_addr_arr [NUM_REQ];
    logic                    w_illegal;
    logic                    w_limit;
    logic [NUM_REQ-1:0]      w_owner_oh;

    // Requests rotated so that offset 0 is the current round-robin pointer.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [SUM_W-1:0] w_sum;
            logic [SUM_W-1:0] w_idx;
            assign w_sum          = {1'b0, r_ptr} + SUM_W'(gi);
            assign w_idx          = (w_sum >= SUM_W'(NUM_REQ)) ? w_sum - SUM_W'(NUM_REQ) : w_sum;
            assign w_rot[gi]      = req[w_idx[PTR_W-1:0]];
            assign w_mode_arr[gi] = req_mode[2*gi +: 2];
            assign w_addr_arr[gi] = req_addr[gi*ADDRESS_SIZE +: ADDRESS_SIZE];
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = PTR_W'(k);
            end
        end
    end

    assign w_win_sum  = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win      = (w_win_sum >= SUM_W'(NUM_REQ)) ? PTR_W'(w_win_sum - SUM_W'(NUM_REQ))
                                                       : w_win_sum[PTR_W-1:0];
    assign w_illegal  = (r_mode == 2'b11) || (r_we == r_re);
    assign w_limit    = (r_cnt == CNT_WIDTH'(MAX_HOLD - 1));
    assign w_owner_oh = NUM_REQ'(1) << r_owner;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_state_next = S_ACTIVE;
            S_ACTIVE:  if (w_illegal || ub_done || w_limit) w_state_next = S_RELEASE;
            S_RELEASE: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_we         <= 1'b0;
            r_re         <= 1'b0;
            r_mode       <= 2'b00;
            r_section    <= 1'b0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_done_pulse <= 1'b0;
            r_err_pulse  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            // Completion of a legal command is reported in the RELEASE cycle.
            r_done_pulse <= (r_state == S_ACTIVE) && !w_illegal && (ub_done || w_limit);
            r_err_pulse  <= (r_state == S_ACTIVE) && !w_illegal && !ub_done && w_limit;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner   <= w_win;
                        r_we      <= req_we[w_win];
                        r_re      <= req_re[w_win];
                        r_mode    <= w_mode_arr[w_win];
                        r_section <= req_section[w_win];
                        r_addr    <= w_addr_arr[w_win];
                    end
                end
                S_ACTIVE: r_cnt <= r_cnt + 1'b1;
                S_RELEASE: begin
                    r_cnt <= '0;
                    r_ptr <= (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        gnt           = '0;
        done          = '0;
        timeout_err   = 1'b0;
        busy          = (r_state != S_IDLE);
        ub_we         = 1'b0;
        ub_re         = 1'b0;
        ub_fifo_en    = 1'b0;
        ub_compute_en = 1'b0;
        ub_store_en   = 1'b0;
        ub_section    = 1'b0;
        ub_address    = '0;
        case (r_state)
            S_ACTIVE: begin
                gnt        = w_owner_oh;
                ub_section = r_section;
                ub_address = r_addr;
                if (w_illegal) begin
                    done        = w_owner_oh;
                    timeout_err = 1'b1;
                end else begin
                    ub_we         = r_we;
                    ub_re         = r_re;
                    ub_fifo_en    = (r_mode == 2'b00);
                    ub_compute_en = (r_mode == 2'b01);
                    ub_store_en   = (r_mode == 2'b10);
                end
            end
            S_RELEASE: begin
                done        = r_done_pulse ? w_owner_oh : '0;
                timeout_err = r_err_pulse;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ub_arbiter.sv
// Bench for ub_arbiter: directed scenarios followed by randomized transactions,
// each checked against a transaction-level round-robin model.
module tb_ub_arbiter;
    localparam int N  = 4;
    localparam int AW = 9;
    localparam int MH = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, req_we, req_re, req_section;
    logic [2*N-1:0]  req_mode;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt, done;
    logic            timeout_err, busy, ub_we, ub_re;
    logic            ub_fifo_en, ub_compute_en, ub_store_en, ub_section;
    logic [AW-1:0]   ub_address;
    logic            ub_done;

    int checks = 0;
    int errors = 0;
    int ptr    = 0;

    ub_arbiter #(.NUM_REQ(N), .ADDRESS_SIZE(AW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_re(req_re),
        .req_mode(req_mode), .req_section(req_section), .req_addr(req_addr),
        .gnt(gnt), .done(done), .timeout_err(timeout_err), .busy(busy),
        .ub_we(ub_we), .ub_re(ub_re), .ub_fifo_en(ub_fifo_en),
        .ub_compute_en(ub_compute_en), .ub_store_en(ub_store_en),
        .ub_section(ub_section), .ub_address(ub_address), .ub_done(ub_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] enables();
        return {ub_we, ub_re, ub_fifo_en, ub_compute_en, ub_store_en};
    endfunction

    task automatic check_all_zero(input string tag, input logic exp_busy);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(timeout_err), 0);
        check({tag, "_en"}, 32'(enables()), 0);
        check({tag, "_addr"}, 32'({ub_section, ub_address}), 0);
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    endtask

    task automatic scramble;
        req         = N'($urandom);
        req_we      = N'($urandom);
        req_re      = N'($urandom);
        req_mode    = (2*N)'($urandom);
        req_section = N'($urandom);
        req_addr    = (N*AW)'({$urandom, $urandom});
    endtask

    // First set request at or after p, scanning cyclically.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Starts in an IDLE cycle; ub_done is pulsed on ACTIVE cycle d (never if d > MH).
    task automatic run_txn(input logic [N-1:0] rq, input logic [N-1:0] we, input logic [N-1:0] re,
                           input logic [2*N-1:0] md, input logic [N-1:0] sec,
                           input logic [N*AW-1:0] ad, input int d);
        int            w;
        logic [N-1:0]  oh;
        logic [1:0]    m;
        logic          legal;
        logic [4:0]    exp_en;
        logic [AW-1:0] exp_addr;
        w        = pick(rq, ptr);
        oh       = N'(1) << w;
        m        = md[2*w +: 2];
        legal    = (m != 2'b11) && (we[w] != re[w]);
        exp_addr = ad[w*AW +: AW];
        exp_en   = legal ? {we[w], re[w], m == 2'b00, m == 2'b01, m == 2'b10} : 5'b0;
        req = rq; req_we = we; req_re = re; req_mode = md; req_section = sec; req_addr = ad;
        ub_done = 1'($urandom);
        tick;
        check("gnt", 32'(gnt), 32'(oh));
        check("busy_active", 32'(busy), 1);
        check("enables", 32'(enables()), 32'(exp_en));
        check("address", 32'({ub_section, ub_address}), 32'({sec[w], exp_addr}));
        check("illegal_done", 32'(done), legal ? 0 : 32'(oh));
        check("illegal_err", 32'(timeout_err), 32'(!legal));
        scramble;
        ub_done = 1'b0;
        if (legal) begin
            for (int k = 1; k <= MH; k++) begin
                ub_done = (k == d);
                tick;
                scramble;
                ub_done = 1'b0;
                if (k == d || k == MH) break;
                check("hold_gnt", 32'(gnt), 32'(oh));
                check("hold_addr", 32'(ub_address), 32'(exp_addr));
                check("hold_done", 32'({done, timeout_err}), 0);
            end
        end else begin
            tick;
        end
        check("rel_gnt", 32'(gnt), 0);
        check("rel_busy", 32'(busy), 1);
        check("rel_en", 32'(enables()), 0);
        check("rel_addr", 32'({ub_section, ub_address}), 0);
        check("rel_done", 32'(done), legal ? 32'(oh) : 0);
        check("rel_err", 32'(timeout_err), 32'(legal && d > MH));
        ub_done = 1'($urandom);
        tick;
        check_all_zero("idle", 1'b0);
        ptr = (w + 1) % N;
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; req_we = '0; req_re = '0; req_mode = '0; req_section = '0; req_addr = '0;
        ub_done = 1'b0;
        #12;
        check_all_zero("reset", 1'b0);
        rst_n = 1'b1;
        tick;

        // Single write from requester 1
        run_txn(4'b0010, 4'b0010, 4'b0000, 8'b00_00_00_00, 4'b0010,
                {9'h000, 9'h000, 9'h1A5, 9'h000}, 3);

        // Reset in the middle of an active write
        req = 4'b0001; req_we = 4'b0001; req_re = '0; req_mode = '0;
        tick;
        check("pre_reset_we", 32'(ub_we), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset", 1'b0);
        tick;
        check_all_zero("held_reset", 1'b0);
        rst_n = 1'b1;
        ptr = 0;
        req = '0;
        tick;
        run_txn(4'b0100, 4'b0100, 4'b0000, 8'b00_01_00_00, 4'b0000, {4{9'h0C3}}, 2);

        // Round-robin with all requesters pending
        for (int i = 0; i < 5; i++)
            run_txn(4'b1111, 4'b1111, 4'b0000, 8'b10_01_00_00, 4'b1010,
                    {9'h033, 9'h022, 9'h011, 9'h100}, 2);

        // Timeout, tie at the limit, and an illegal command
        run_txn(4'b1000, 4'b0000, 4'b1000, 8'b01_00_00_00, 4'b1000, {9'h1FF, 27'h0}, MH + 5);
        run_txn(4'b0001, 4'b0001, 4'b0000, 8'b00_00_00_10, 4'b0000, {27'h0, 9'h055}, MH);
        run_txn(4'b0001, 4'b0001, 4'b0001, 8'b00_00_00_00, 4'b0000, {27'h0, 9'h0AA}, 1);
        run_txn(4'b1111, 4'b0010, 4'b0000, 8'b00_00_00_00, 4'b0000, {4{9'h011}}, 1);

        // Randomized transactions
        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] rq;
            rq = N'($urandom_range(1, (1 << N) - 1));
            run_txn(rq, N'($urandom), N'($urandom), (2*N)'($urandom), N'($urandom),
                    (N*AW)'({$urandom, $urandom}), $urandom_range(1, MH + 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
